// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encodings, loss-counter
// width and the helper that picks shortened delays for simulation builds.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    FILT = 2'd1,
    REL  = 2'd2,
    RUN  = 2'd3
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;
  localparam int SIM_DLY    = 4;

  // Simulation builds collapse every programmable delay to SIM_DLY cycles.
  function automatic int eff_dly(input bit sim, input int dly);
    return sim ? SIM_DLY : dly;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Bank of 2-flop synchronisers; rst clears every stage to the "not ready" level.
module rst_seq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Ordered, lock-qualified reset sequencer: releases rst_out bits in ascending order.
// Optional lock-loss event counter is built when RST_LOSS_CNT_EN is defined.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int    CH_NUM     = 4,
  parameter int    FILT_CYC   = 16,
  parameter int    STAGE_DLY  = 64,
  parameter int    HOLD_MIN   = 8,
  parameter int    CNT_W      = 16,
  parameter string SIMULATION = "FALSE"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rstn_in,
  input  logic [CH_NUM-1:0]     pll_locked,
  input  logic                  sw_rst_req,
  output logic [CH_NUM-1:0]     rst_out,
  output logic                  rst_done,
  output logic [1:0]            seq_state,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam bit SIM_EN = (SIMULATION == "TRUE");
  localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(eff_dly(SIM_EN, HOLD_MIN) - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(eff_dly(SIM_EN, FILT_CYC) - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(eff_dly(SIM_EN, STAGE_DLY) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CH_NUM - 1);

  logic              rstn_s;
  logic [CH_NUM-1:0] locked_s;

  rst_seq_sync #(.W(CH_NUM + 1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({rstn_in, pll_locked}),
    .q   ({rstn_s, locked_s})
  );

  logic locked_all, qual;
  assign locked_all = &locked_s;
  assign qual       = rstn_s & locked_all & ~sw_rst_req;

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CH_NUM-1:0] rst_out_nxt;
  logic              done_nxt;
  logic              stage_tc, last_tc;

  assign stage_tc = (state == REL) && (cnt == STG_LAST);
  assign last_tc  = stage_tc && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HOLD;
    else     state <= state_nxt;
  end

  // Losing qualification outranks every other transition, including a stage terminal count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nxt = state;
    unique case (state)
      HOLD: if (qual && cnt == HOLD_LAST) state_nxt = FILT;
      FILT: if (!qual) state_nxt = HOLD;
            else if (cnt == FILT_LAST) state_nxt = REL;
      REL:  if (!qual) state_nxt = HOLD;
            else if (last_tc) state_nxt = RUN;
      RUN:  if (!qual) state_nxt = HOLD;
    endcase
  end

  // Counter is shared by all states and starts from zero on every state change.
  always_comb begin
    cnt_nxt     = '0;
    idx_nxt     = idx;
    rst_out_nxt = rst_out;
    done_nxt    = 1'b0;
    unique case (state_nxt)
      HOLD: begin
        rst_out_nxt = '1;
        idx_nxt     = '0;
        if (state == HOLD) cnt_nxt = (cnt == HOLD_LAST) ? cnt : cnt + CNT_W'(1);
      end
      FILT: if (state == FILT) cnt_nxt = cnt + CNT_W'(1);
      REL: begin
        if (stage_tc) begin
          rst_out_nxt[idx] = 1'b0;
          idx_nxt          = idx + IDX_W'(1);
        end else if (state == REL) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (state == REL) rst_out_nxt[idx] = 1'b0;
        done_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      rst_out  <= '1;
      rst_done <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      rst_out  <= rst_out_nxt;
      rst_done <= done_nxt;
    end
  end

  assign seq_state = state;

`ifdef RST_LOSS_CNT_EN
  logic                  locked_all_d;
  logic                  loss_evt;
  logic [LOSS_CNT_W-1:0] loss_q;

  assign loss_evt = locked_all_d & ~locked_all & ((state == REL) || (state == RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_all_d <= 1'b0;
      loss_q       <= '0;
    end else begin
      locked_all_d <= locked_all;
      if (loss_evt && loss_q != '1) loss_q <= loss_q + LOSS_CNT_W'(1);
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default 4-channel instance plus a
// SIMULATION="TRUE" 2-channel instance sharing clk and rst.
module tb_rst_seq_gen;

`ifdef RST_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rstn_in, sw_rst_req;
  logic [3:0] pll_locked;
  logic [3:0] rst_out;
  logic       rst_done;
  logic [1:0] seq_state;
  logic [7:0] loss_cnt;

  logic       s_rstn, s_sw;
  logic [1:0] s_locked, s_out, s_state;
  logic       s_done;
  logic [7:0] s_loss;

  always #5 clk = ~clk;

  rst_seq_gen u_dut (
    .clk        (clk),
    .rst        (rst),
    .rstn_in    (rstn_in),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .rst_done   (rst_done),
    .seq_state  (seq_state),
    .loss_cnt   (loss_cnt)
  );

  rst_seq_gen #(.CH_NUM(2), .SIMULATION("TRUE")) u_sim (
    .clk        (clk),
    .rst        (rst),
    .rstn_in    (s_rstn),
    .pll_locked (s_locked),
    .sw_rst_req (s_sw),
    .rst_out    (s_out),
    .rst_done   (s_done),
    .seq_state  (s_state),
    .loss_cnt   (s_loss)
  );

  typedef struct {
    int unsigned cyc;
    logic        rstn;
    logic [3:0]  lock;
    logic        sw;
    logic [3:0]  exp_out;
    logic        exp_done;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   order_err = 0;

  // rst_out may only ever show a thermometer pattern released from bit 0 upwards.
  always @(negedge clk)
    if (!(rst_out inside {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000})) order_err++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input int unsigned cyc, input logic sw, input logic [3:0] eo,
                     input logic ed, input logic [1:0] es);
    vec_t v;
    v.cyc = cyc; v.rstn = 1'b1; v.lock = 4'b1111; v.sw = sw;
    v.exp_out = eo; v.exp_done = ed; v.exp_state = es;
    vecs.push_back(v);
  endtask

  task automatic check_main(input string tag, input logic [3:0] eo, input logic ed,
                            input logic [1:0] es);
    check($sformatf("%s rst_out", tag), rst_out, eo);
    check($sformatf("%s rst_done", tag), rst_done, ed);
    check($sformatf("%s seq_state", tag), seq_state, es);
  endtask

  task automatic wait_out(input logic [3:0] pat, input int bound, input string tag);
    int n = 0;
    while (rst_out !== pat && n < bound) begin step(1); n++; end
    check($sformatf("%s reached", tag), rst_out, pat);
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n = 0;
    while (rst_done !== 1'b1 && n < bound) begin step(1); n++; end
    check_main(tag, 4'b0000, 1'b1, 2'd3);
  endtask

  initial begin
    int early, tmo, n;

    rst = 1'b1; rstn_in = 1'b1; pll_locked = 4'b1111; sw_rst_req = 1'b0;
    s_rstn = 1'b1; s_locked = 2'b11; s_sw = 1'b0;

    // Clean power-up: 8 HOLD + 16 FILT cycles, then one release every 64 cycles.
    add(7, 0, 4'b1111, 0, 2'd0);  add(1, 0, 4'b1111, 0, 2'd1);
    add(15, 0, 4'b1111, 0, 2'd1); add(1, 0, 4'b1111, 0, 2'd2);
    add(63, 0, 4'b1111, 0, 2'd2); add(1, 0, 4'b1110, 0, 2'd2);
    add(63, 0, 4'b1110, 0, 2'd2); add(1, 0, 4'b1100, 0, 2'd2);
    add(63, 0, 4'b1100, 0, 2'd2); add(1, 0, 4'b1000, 0, 2'd2);
    add(63, 0, 4'b1000, 0, 2'd2); add(1, 0, 4'b0000, 1, 2'd3);
    add(5, 0, 4'b0000, 1, 2'd3);
    // Software request in RUN: HOLD next cycle, done again 280 cycles after that edge.
    add(1, 1, 4'b1111, 0, 2'd0);  add(7, 0, 4'b1111, 0, 2'd0);
    add(1, 0, 4'b1111, 0, 2'd1);  add(15, 0, 4'b1111, 0, 2'd1);
    add(1, 0, 4'b1111, 0, 2'd2);  add(255, 0, 4'b1000, 0, 2'd2);
    add(1, 0, 4'b0000, 1, 2'd3);

    step(3);
    check_main("reset", 4'b1111, 1'b0, 2'd0);
    check("reset loss_cnt", loss_cnt, 8'd0);
    check("reset sim rst_out", s_out, 2'b11);
    check("reset sim seq_state", s_state, 2'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      rstn_in = vecs[i].rstn; pll_locked = vecs[i].lock; sw_rst_req = vecs[i].sw;
      step(int'(vecs[i].cyc));
      check_main($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_done, vecs[i].exp_state);
    end
    sw_rst_req = 1'b0;

    // One-cycle rstn_in glitch at filter count 10 restarts HOLD and the full filter.
    sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
    step(7);  check_main("glitch hold", 4'b1111, 1'b0, 2'd0);
    step(1);  check_main("glitch filt0", 4'b1111, 1'b0, 2'd1);
    step(10); rstn_in = 1'b0; step(1); rstn_in = 1'b1;
    step(1);  check_main("glitch sync", 4'b1111, 1'b0, 2'd1);
    step(1);  check_main("glitch abort", 4'b1111, 1'b0, 2'd0);
    step(7);  check_main("glitch rehold", 4'b1111, 1'b0, 2'd0);
    step(1);  check_main("glitch refilt", 4'b1111, 1'b0, 2'd1);
    step(15); check_main("glitch filt15", 4'b1111, 1'b0, 2'd1);
    step(1);  check_main("glitch rel", 4'b1111, 1'b0, 2'd2);

    // Lock loss mid-REL after 1100: all ones three edges after the drop.
    wait_out(4'b1100, 300, "lockloss 1100");
    pll_locked = 4'b1011;
    step(3);
    check_main("lockloss abort", 4'b1111, 1'b0, 2'd0);
    check("lockloss loss_cnt", loss_cnt, LOSS_EN ? 8'd1 : 8'd0);
    pll_locked = 4'b1111;
    wait_done(400, "relock done");

    // Async rst mid-REL acts before the next clock edge.
    sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
    wait_out(4'b1100, 400, "async 1100");
    #2 rst = 1'b1;
    #1 check_main("async rst", 4'b1111, 1'b0, 2'd0);
    check("async loss_cnt", loss_cnt, 8'd0);
    step(2); rst = 1'b0;
    early = 0;
    for (int i = 0; i < 87; i++) begin
      step(1);
      if (rst_out !== 4'b1111) early++;
    end
    check("async no early release", early, 0);
    step(1); check_main("async first fall", 4'b1110, 1'b0, 2'd2);

    // SIMULATION="TRUE", two channels: every delay is 4 cycles.
    s_sw = 1'b1; step(1); s_sw = 1'b0;
    check("sim hold rst_out", s_out, 2'b11);
    check("sim hold state", s_state, 2'd0);
    step(3); check("sim hold3 state", s_state, 2'd0);
    step(1); check("sim filt state", s_state, 2'd1);
    step(3); check("sim filt3 state", s_state, 2'd1);
    step(1); check("sim rel state", s_state, 2'd2);
    step(3); check("sim rel3 rst_out", s_out, 2'b11);
    step(1); check("sim fall0 rst_out", s_out, 2'b10);
    check("sim fall0 done", s_done, 1'b0);
    step(3); check("sim gap rst_out", s_out, 2'b10);
    step(1); check("sim fall1 rst_out", s_out, 2'b00);
    check("sim fall1 done", s_done, 1'b1);
    check("sim fall1 state", s_state, 2'd3);

    // 300 lock-loss events while the short sequencer is in REL or RUN.
    tmo = 0;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (!(s_state inside {2'd2, 2'd3}) && n < 40) begin step(1); n++; end
      if (n >= 40) tmo++;
      s_locked = 2'b00; step(3); s_locked = 2'b11;
    end
    check("sim loss loop timeouts", tmo, 0);
    check("sim loss_cnt saturated", s_loss, LOSS_EN ? 8'd255 : 8'd0);

    check("release order", order_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
